sram_ctrl: RTL and testbench

- Memory-side neighbour of the CPU core: serves the core's instruction-fetch port (romEnable/romAddr/romData) and its future data-memory port from one external asynchronous 16-bit SRAM.
- Multi-cycle FSM with programmable wait states.
- Fixed arbitration between the two ports, with a per-port ready pulse. The core stalls its pipeline until ready.

---
 rtl/sram_ctrl_pkg.sv | 25 ++
 rtl/sram_wait_cnt.sv | 39 +++
 rtl/sram_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller.
//   RegBusW : width of the core-side data/address buses and the SRAM data bus
//   CntW    : width of the wait-state down-counter
//   state_e : controller FSM states
//   port_e  : which core port owns the current access
package sram_ctrl_pkg;

  localparam int unsigned RegBusW = 16;
  localparam int unsigned CntW    = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWSetup,
    StWPulse,
    StWHold,
    StDone
  } state_e;

  typedef enum logic {
    PortInst = 1'b0,
    PortData = 1'b1
  } port_e;

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable wait-state down-counter with a zero flag.
//   clk, rst   : clock, asynchronous active-low reset
//   load_i     : load load_val_i (takes priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one, saturating at zero
//   zero_o     : counter currently holds zero
module sram_wait_cnt
  import sram_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Arbitrating controller between the core's instruction-fetch port and data
// port and one external asynchronous 16-bit SRAM, with programmable wait states.
//   clk, rst                    : clock, asynchronous active-low reset
//   romEnable_i/romAddr_i       : instruction read request (held until ready)
//   romData_o/romReady_o        : fetched word, one-cycle completion pulse
//   ramEnable_i/ramWrite_i      : data request and direction (1 = write)
//   ramAddr_i/ramWData_i        : data address and write data
//   ramRData_o/ramReady_o       : read data, one-cycle completion pulse
//   sramAddr_o/sramData_io      : SRAM address and bidirectional data bus
//   sramCe_n_o/Oe_n_o/We_n_o    : SRAM strobes, active low
// All outputs are registered; the data port wins when both ports request.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18,
  parameter logic [1:0]  INST_BANK   = 2'b00,
  parameter logic [1:0]  DATA_BANK   = 2'b01
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               romEnable_i,
  input  logic [RegBusW-1:0] romAddr_i,
  output logic [RegBusW-1:0] romData_o,
  output logic               romReady_o,
  input  logic               ramEnable_i,
  input  logic               ramWrite_i,
  input  logic [RegBusW-1:0] ramAddr_i,
  input  logic [RegBusW-1:0] ramWData_i,
  output logic [RegBusW-1:0] ramRData_o,
  output logic               ramReady_o,
  output logic [SRAM_AW-1:0] sramAddr_o,
  inout  wire  [RegBusW-1:0] sramData_io,
  output logic               sramCe_n_o,
  output logic               sramOe_n_o,
  output logic               sramWe_n_o
);

  localparam logic [CntW-1:0] LoadVal = CntW'(WAIT_CYCLES - 1);

  state_e state_d, state_q;
  logic   cnt_load, cnt_dec, cnt_zero;

  port_e              port_d, port_q;
  logic               write_d, write_q;
  logic               abort_d, abort_q;
  logic [RegBusW-1:0] wdata_d, wdata_q;
  logic [SRAM_AW-1:0] addr_d, addr_q;
  logic [RegBusW-1:0] rom_data_d, rom_data_q;
  logic [RegBusW-1:0] ram_rdata_d, ram_rdata_q;
  logic               rom_ready_d, rom_ready_q;
  logic               ram_ready_d, ram_ready_q;
  logic               ce_n_d, ce_n_q;
  logic               oe_n_d, oe_n_q;
  logic               we_n_d, we_n_q;
  logic               data_oe_d, data_oe_q;

  logic accept, finish, sel_en, fin_ok;

  sram_wait_cnt u_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(LoadVal),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and wait-counter control
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ramEnable_i) begin
          state_d = ramWrite_i ? StWSetup : StRead;
        end else if (romEnable_i) begin
          state_d = StRead;
        end
        cnt_load = (state_d == StRead);
      end
      StRead: begin
        if (cnt_zero) state_d = StDone;
        else          cnt_dec = 1'b1;
      end
      StWSetup: begin
        state_d  = StWPulse;
        cnt_load = 1'b1;
      end
      StWPulse: begin
        if (cnt_zero) state_d = StWHold;
        else          cnt_dec = 1'b1;
      end
      StWHold: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values; strobes follow the state being entered
  // so that the registered pins line up with the state they belong to.
  always_comb begin
    accept = (state_q == StIdle) && (state_d != StIdle);
    finish = (state_d == StDone) && (state_q != StDone);
    sel_en = (port_q == PortData) ? ramEnable_i : romEnable_i;
    fin_ok = finish && sel_en && !abort_q;

    port_d      = port_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    rom_data_d  = rom_data_q;
    ram_rdata_d = ram_rdata_q;

    // Sticky: once the owner drops its enable, the access completes silently.
    abort_d = abort_q;
    if (state_q != StIdle && state_q != StDone && !sel_en) abort_d = 1'b1;

    if (accept) begin
      abort_d = 1'b0;
      if (ramEnable_i) begin
        port_d  = PortData;
        write_d = ramWrite_i;
        addr_d  = SRAM_AW'({DATA_BANK, ramAddr_i});
        wdata_d = ramWData_i;
      end else begin
        port_d  = PortInst;
        write_d = 1'b0;
        addr_d  = SRAM_AW'({INST_BANK, romAddr_i});
      end
    end

    if (fin_ok && !write_q) begin
      if (port_q == PortData) ram_rdata_d = sramData_io;
      else                    rom_data_d  = sramData_io;
    end

    rom_ready_d = fin_ok && (port_q == PortInst);
    ram_ready_d = fin_ok && (port_q == PortData);

    data_oe_d = (state_d == StWSetup) || (state_d == StWPulse) || (state_d == StWHold);
    ce_n_d    = !((state_d == StRead) || data_oe_d);
    oe_n_d    = (state_d != StRead);
    we_n_d    = (state_d != StWPulse);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_q      <= PortInst;
      write_q     <= 1'b0;
      abort_q     <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
      rom_data_q  <= '0;
      ram_rdata_q <= '0;
      rom_ready_q <= 1'b0;
      ram_ready_q <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      data_oe_q   <= 1'b0;
    end else begin
      port_q      <= port_d;
      write_q     <= write_d;
      abort_q     <= abort_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      rom_data_q  <= rom_data_d;
      ram_rdata_q <= ram_rdata_d;
      rom_ready_q <= rom_ready_d;
      ram_ready_q <= ram_ready_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign sramData_io = data_oe_q ? wdata_q : 'z;

  assign romData_o  = rom_data_q;
  assign ramRData_o = ram_rdata_q;
  assign romReady_o = rom_ready_q;
  assign ramReady_o = ram_ready_q;
  assign sramAddr_o = addr_q;
  assign sramCe_n_o = ce_n_q;
  assign sramOe_n_o = oe_n_q;
  assign sramWe_n_o = we_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with an asynchronous SRAM model on the bus.
module tb_sram_ctrl;

  localparam int unsigned Wait = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        romEnable = 1'b0;
  logic [15:0] romAddr = '0;
  logic [15:0] romData;
  logic        romReady;
  logic        ramEnable = 1'b0;
  logic        ramWrite = 1'b0;
  logic [15:0] ramAddr = '0;
  logic [15:0] ramWData = '0;
  logic [15:0] ramRData;
  logic        ramReady;
  logic [17:0] sramAddr;
  wire  [15:0] sramData;
  logic        ce_n, oe_n, we_n;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [15:0] exp_rom = '0;
  logic [15:0] exp_ram = '0;

  // SRAM model: bank bits plus the low address byte select a word
  logic [15:0] mem [0:1023];
  logic [9:0]  sidx;
  assign sidx = {sramAddr[17:16], sramAddr[7:0]};
  assign sramData = (!ce_n && !oe_n && we_n) ? mem[sidx] : 'z;

  always @(posedge clk) begin
    if (!ce_n && !we_n) mem[sidx] <= sramData;
  end

  always #5 clk = ~clk;

  sram_ctrl #(
    .WAIT_CYCLES(Wait)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .romEnable_i(romEnable),
    .romAddr_i  (romAddr),
    .romData_o  (romData),
    .romReady_o (romReady),
    .ramEnable_i(ramEnable),
    .ramWrite_i (ramWrite),
    .ramAddr_i  (ramAddr),
    .ramWData_i (ramWData),
    .ramRData_o (ramRData),
    .ramReady_o (ramReady),
    .sramAddr_o (sramAddr),
    .sramData_io(sramData),
    .sramCe_n_o (ce_n),
    .sramOe_n_o (oe_n),
    .sramWe_n_o (we_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int midx(input bit is_ram, input logic [15:0] a);
    return {is_ram ? 2'b01 : 2'b00, a[7:0]};
  endfunction

  // Output enable and write enable / bus drive must never overlap.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (!oe_n) begin
        check_eq("oe_we_excl", 32'(we_n), 32'd1);
        check_eq("oe_bus_drv", 32'(dut.data_oe_q), 32'd0);
      end
      if (!we_n) check_eq("we_oe_excl", 32'(oe_n), 32'd1);
    end
  end

  // One access from the IDLE cycle; checks latency, data and ready exclusivity.
  task automatic run_access(input bit is_ram, input bit wr, input logic [15:0] a,
                            input logic [15:0] wd);
    int cyc = 0;
    bit seen = 1'b0;
    logic [15:0] exp_rd = mem[midx(is_ram, a)];
    if (is_ram) begin
      ramEnable = 1'b1; ramWrite = wr; ramAddr = a; ramWData = wd;
    end else begin
      romEnable = 1'b1; romAddr = a;
    end
    while (cyc < 40 && !seen) begin
      tick();
      cyc++;
      if (romReady && ramReady) check_eq("both_ready", 32'd1, 32'd0);
      seen = is_ram ? ramReady : romReady;
    end
    ramEnable = 1'b0;
    romEnable = 1'b0;
    if (!seen) begin
      check_eq("ready_timeout", 32'd0, 32'd1);
    end else begin
      check_eq(wr ? "wr_latency" : "rd_latency", 32'(cyc), wr ? 32'(Wait + 3) : 32'(Wait + 1));
      if (!wr) begin
        if (is_ram) exp_ram = exp_rd;
        else        exp_rom = exp_rd;
      end
      check_eq("rom_data", 32'(romData), 32'(exp_rom));
      check_eq("ram_data", 32'(ramRData), 32'(exp_ram));
    end
    tick();
  endtask

  initial begin
    int rom_at, ram_at;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 16'h1111) ^ 16'hA5C3;
    mem[midx(1'b0, 16'h0040)] = 16'h1234;

    // Reset state
    #1 rst = 1'b0;
    tick(); tick();
    check_eq("rst_ce", 32'(ce_n), 32'd1);
    check_eq("rst_oe", 32'(oe_n), 32'd1);
    check_eq("rst_we", 32'(we_n), 32'd1);
    check_eq("rst_drv", 32'(dut.data_oe_q), 32'd0);
    check_eq("rst_rdy", 32'({romReady, ramReady}), 32'd0);
    check_eq("rst_data", 32'({romData, ramRData}), 32'd0);
    check_eq("rst_addr", 32'(sramAddr), 32'd0);
    rst = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("idle_ce", 32'(ce_n), 32'd1);
    end

    // Instruction read, cycle by cycle
    romEnable = 1'b1; romAddr = 16'h0040;
    tick();
    check_eq("ir_c1_oe", 32'(oe_n), 32'd0);
    check_eq("ir_c1_ce", 32'(ce_n), 32'd0);
    check_eq("ir_c1_addr", 32'(sramAddr), 32'h00040);
    check_eq("ir_c1_rdy", 32'(romReady), 32'd0);
    tick();
    check_eq("ir_c2_oe", 32'(oe_n), 32'd0);
    check_eq("ir_c2_rdy", 32'(romReady), 32'd0);
    tick();
    check_eq("ir_c3_rdy", 32'(romReady), 32'd1);
    check_eq("ir_c3_data", 32'(romData), 32'h1234);
    check_eq("ir_c3_oe", 32'(oe_n), 32'd1);
    exp_rom = 16'h1234;
    romEnable = 1'b0;
    tick();
    check_eq("ir_c4_rdy", 32'(romReady), 32'd0);

    // Data write, cycle by cycle
    ramEnable = 1'b1; ramWrite = 1'b1; ramAddr = 16'h0010; ramWData = 16'hBEEF;
    tick();
    check_eq("dw_c1_we", 32'(we_n), 32'd1);
    check_eq("dw_c1_ce", 32'(ce_n), 32'd0);
    check_eq("dw_c1_addr", 32'(sramAddr), 32'h10010);
    ramAddr = 16'h0077; ramWData = 16'h0000;  // must be ignored after acceptance
    tick();
    check_eq("dw_c2_we", 32'(we_n), 32'd0);
    check_eq("dw_c2_bus", 32'(sramData), 32'hBEEF);
    tick();
    check_eq("dw_c3_we", 32'(we_n), 32'd0);
    tick();
    check_eq("dw_c4_we", 32'(we_n), 32'd1);
    check_eq("dw_c4_rdy", 32'(ramReady), 32'd0);
    tick();
    check_eq("dw_c5_rdy", 32'(ramReady), 32'd1);
    check_eq("dw_c5_romdata", 32'(romData), 32'h1234);
    ramEnable = 1'b0; ramWrite = 1'b0;
    tick();
    run_access(1'b1, 1'b0, 16'h0010, 16'h0);
    check_eq("rb_beef", 32'(ramRData), 32'hBEEF);

    // Simultaneous requests: data first, instruction after a second access
    rom_at = -1; ram_at = -1;
    romEnable = 1'b1; romAddr = 16'h0041;
    ramEnable = 1'b1; ramWrite = 1'b0; ramAddr = 16'h0020;
    exp_ram = mem[midx(1'b1, 16'h0020)];
    exp_rom = mem[midx(1'b0, 16'h0041)];
    for (int c = 1; c <= 20 && rom_at < 0; c++) begin
      tick();
      if (romReady && ramReady) check_eq("sim_both", 32'd1, 32'd0);
      if (ramReady) begin ram_at = c; ramEnable = 1'b0; end
      if (romReady) begin rom_at = c; romEnable = 1'b0; end
    end
    romEnable = 1'b0; ramEnable = 1'b0;
    check_eq("sim_ram_at", 32'(ram_at), 32'(Wait + 1));
    check_eq("sim_rom_at", 32'(rom_at), 32'(2 * Wait + 3));
    check_eq("sim_ram_data", 32'(ramRData), 32'(exp_ram));
    check_eq("sim_rom_data", 32'(romData), 32'(exp_rom));
    tick();

    // Enable dropped during READ: no ready, data unchanged
    romEnable = 1'b1; romAddr = 16'h0042;
    tick();
    romEnable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("ab_rdy", 32'(romReady), 32'd0);
    end
    check_eq("ab_data", 32'(romData), 32'(exp_rom));

    // Random request mix
    for (int i = 0; i < 30; i++) begin
      bit          is_ram = 1'($urandom_range(0, 1));
      bit          wr = is_ram & 1'($urandom_range(0, 1));
      logic [15:0] a = 16'($urandom_range(0, 255));
      run_access(is_ram, wr, a, 16'($urandom));
    end

    // Reset during W_PULSE aborts immediately
    ramEnable = 1'b1; ramWrite = 1'b1; ramAddr = 16'h0030; ramWData = 16'h1357;
    tick(); tick();
    check_eq("rw_pulse_we", 32'(we_n), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rw_we", 32'(we_n), 32'd1);
    check_eq("rw_ce", 32'(ce_n), 32'd1);
    check_eq("rw_drv", 32'(dut.data_oe_q), 32'd0);
    check_eq("rw_rdy", 32'({romReady, ramReady}), 32'd0);
    check_eq("rw_data", 32'({romData, ramRData}), 32'd0);
    ramEnable = 1'b0; ramWrite = 1'b0;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("post_rst_rdy", 32'(ramReady), 32'd0);
      check_eq("post_rst_ce", 32'(ce_n), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
